tick_go_gen: RTL

- Timing front end that generates the stimulus consumed by the LED sequencer: a one-clock 1 kHz tick pulse and a one-clock "go" pulse taken from a debounced push button.
- Sits between the board clock and button pins and the sequencer inputs (tick pulse and start strobe).
- Contains a free-running prescaler, a 2-FF button synchroniser and a 4-state debounce FSM clocked by the prescaler tick.

---
 rtl/tick_go_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tick_go_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tick_go_gen
//   Timing front end for the LED sequencer. It produces a one-clock tick pulse
//   at TICK_HZ from a free-running prescaler, and a one-clock "go" strobe for
//   each debounced button press. The button is brought into the clock domain
//   through a 2-FF synchroniser and filtered by a debounce FSM that advances on
//   the prescaler tick.
//
// Ports
//   i_clk      system clock (CLK_FREQ Hz), rising edge
//   i_rstn     asynchronous active-low reset
//   i_en       enables o_pls_1k only; the prescaler phase keeps running
//   i_btn      raw push button, active-high, asynchronous to i_clk
//   o_pls_1k   one-clock tick pulse every DIV clocks while i_en=1
//   o_go       one-clock pulse per accepted (debounced) press
//   o_btn_lvl  debounced button level
//
// Debounce FSM
//   state           | meaning
//   ----------------+-----------------------------------------------------
//   ST_IDLE         | button settled released
//   ST_PRESS_WAIT   | btn_s high, counting stable ticks before accepting
//   ST_PRESSED      | button settled pressed
//   ST_RELEASE_WAIT | btn_s low, counting stable ticks before accepting
// -----------------------------------------------------------------------------
module tick_go_gen #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    input  logic i_btn,
    output logic o_pls_1k,
    output logic o_go,
    output logic o_btn_lvl
);

    localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned DW  = $clog2(DEBOUNCE_MS + 1);

    localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DBC_LAST = DW'(DEBOUNCE_MS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic          btn_s1_q, btn_s2_q;
    logic          btn_s;
    logic [DW-1:0] dbc_q, dbc_d;
    state_t        state_q, state_d;
    logic          pls_q, pls_d;
    logic          go_q, go_d;
    logic          lvl_q, lvl_d;

    // Prescaler free-runs regardless of i_en so re-enabling keeps the phase.
    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    assign pls_d = tick & i_en;

    assign btn_s = btn_s2_q;

    always_comb begin
        state_d = state_q;
        dbc_d   = dbc_q;

        // The level check on btn_s is tested before the tick so that a bounce
        // landing on the final tick aborts the wait instead of accepting it.
        case (state_q)
            ST_IDLE: begin
                if (btn_s) state_d = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!btn_s)                          state_d = ST_IDLE;
                else if (tick && (dbc_q == DBC_LAST)) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!btn_s) state_d = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (btn_s)                           state_d = ST_PRESSED;
                else if (tick && (dbc_q == DBC_LAST)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            dbc_d = '0;
        end else if (tick && ((state_q == ST_PRESS_WAIT) ||
                              (state_q == ST_RELEASE_WAIT))) begin
            dbc_d = dbc_q + 1'b1;
        end

        go_d  = (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);
        lvl_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q    <= '0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            dbc_q    <= '0;
            state_q  <= ST_IDLE;
            pls_q    <= 1'b0;
            go_q     <= 1'b0;
            lvl_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            btn_s1_q <= i_btn;
            btn_s2_q <= btn_s1_q;
            dbc_q    <= dbc_d;
            state_q  <= state_d;
            pls_q    <= pls_d;
            go_q     <= go_d;
            lvl_q    <= lvl_d;
        end
    end

    assign o_pls_1k  = pls_q;
    assign o_go      = go_q;
    assign o_btn_lvl = lvl_q;

endmodule
